// File: rtl/id_decode_stage.sv
// MIPS32 ID stage: register file with WB write-through bypass, control decode, sign extend, load-use stall.
// Zero-cycle combinational outputs; Stall holds IF and forces a control bubble into ID/EX.
module id_decode_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction_ID,
    input  logic [31:0] PC_Plus_4_ID,
    input  logic        RegWrite_WB,
    input  logic [4:0]  Write_Register_WB,
    input  logic [31:0] Write_Data_WB,
    input  logic        MemRead_EX,
    input  logic [4:0]  Rt_EX,
    output logic        RegWrite_ID,
    output logic        MemtoReg_ID,
    output logic        Branch_ID,
    output logic        MemRead_ID,
    output logic        MemWrite_ID,
    output logic        RegDst_ID,
    output logic        ALUSrc_ID,
    output logic [1:0]  ALUOp_ID,
    output logic [31:0] Read_Data_1_ID,
    output logic [31:0] Read_Data_2_ID,
    output logic [31:0] Sign_Extend_Instruction_ID,
    output logic        Stall,
    output logic        Illegal_Opcode_ID
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [31:0] rf [0:31];
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wb_wr;
    logic        rt_is_src;
    logic        hazard;
    logic [8:0]  ctl;
    logic        illegal;

    assign opcode = Instruction_ID[31:26];
    assign rs     = Instruction_ID[25:21];
    assign rt     = Instruction_ID[20:16];
    assign wb_wr  = RegWrite_WB && (Write_Register_WB != 5'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (wb_wr) begin
            rf[Write_Register_WB] <= Write_Data_WB;
        end
    end

    // Entry 0 is never written, but reads of $0 are forced to zero explicitly anyway.
    always_comb begin
        Read_Data_1_ID = 32'd0;
        Read_Data_2_ID = 32'd0;
        if (!Reset) begin
            if (rs != 5'd0)
                Read_Data_1_ID = (wb_wr && Write_Register_WB == rs) ? Write_Data_WB : rf[rs];
            if (rt != 5'd0)
                Read_Data_2_ID = (wb_wr && Write_Register_WB == rt) ? Write_Data_WB : rf[rt];
        end
    end

    assign Sign_Extend_Instruction_ID = {{16{Instruction_ID[15]}}, Instruction_ID[15:0]};

    assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign hazard    = MemRead_EX && (Rt_EX != 5'd0) &&
                       ((Rt_EX == rs) || ((Rt_EX == rt) && rt_is_src));
    assign Stall     = hazard && !Reset;

    // ctl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    always_comb begin
        ctl     = 9'd0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: ctl = 9'b1_0_0_1_0_0_0_10;
            OP_LW:    ctl = 9'b0_1_1_1_1_0_0_00;
            OP_SW:    ctl = 9'b0_1_0_0_0_1_0_00;
            OP_BEQ:   ctl = 9'b0_0_0_0_0_0_1_01;
            OP_ADDI:  ctl = 9'b0_1_0_1_0_0_0_00;
            default:  illegal = 1'b1;
        endcase
        if (Reset || hazard) begin
            ctl     = 9'd0;
            illegal = 1'b0;
        end
    end

    assign RegDst_ID         = ctl[8];
    assign ALUSrc_ID         = ctl[7];
    assign MemtoReg_ID       = ctl[6];
    assign RegWrite_ID       = ctl[5];
    assign MemRead_ID        = ctl[4];
    assign MemWrite_ID       = ctl[3];
    assign Branch_ID         = ctl[2];
    assign ALUOp_ID          = ctl[1:0];
    assign Illegal_Opcode_ID = illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboarded random + directed bench for id_decode_stage against a table-driven reference model.
module tb_id_decode_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instruction_ID;
    logic [31:0] PC_Plus_4_ID;
    logic        RegWrite_WB;
    logic [4:0]  Write_Register_WB;
    logic [31:0] Write_Data_WB;
    logic        MemRead_EX;
    logic [4:0]  Rt_EX;
    logic        RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID;
    logic [1:0]  ALUOp_ID;
    logic [31:0] Read_Data_1_ID, Read_Data_2_ID, Sign_Extend_Instruction_ID;
    logic        Stall, Illegal_Opcode_ID;

    always #5 Clk = ~Clk;

    id_decode_stage dut (
        .Clk(Clk), .Reset(Reset), .Instruction_ID(Instruction_ID), .PC_Plus_4_ID(PC_Plus_4_ID),
        .RegWrite_WB(RegWrite_WB), .Write_Register_WB(Write_Register_WB), .Write_Data_WB(Write_Data_WB),
        .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
        .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .Branch_ID(Branch_ID),
        .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegDst_ID(RegDst_ID),
        .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
        .Read_Data_1_ID(Read_Data_1_ID), .Read_Data_2_ID(Read_Data_2_ID),
        .Sign_Extend_Instruction_ID(Sign_Extend_Instruction_ID),
        .Stall(Stall), .Illegal_Opcode_ID(Illegal_Opcode_ID)
    );

    typedef struct packed {
        logic [8:0]  ctl;
        logic        ill;
        logic        stall;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_regs [32];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'd0, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                           input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // Control table as listed for the ISA subset: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}
    function automatic logic [9:0] ctl_table(input logic [5:0] op);
        case (op)
            6'd0:  return {1'b0, 9'b100100010};
            6'd35: return {1'b0, 9'b011110000};
            6'd43: return {1'b0, 9'b010001000};
            6'd4:  return {1'b0, 9'b000000101};
            6'd8:  return {1'b0, 9'b010100000};
            default: return {1'b1, 9'd0};
        endcase
    endfunction

    function automatic logic [31:0] mdl_read(input logic rst, input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (rst || a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return mdl_regs[a];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] instr, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic mr, input logic [4:0] rtex);
        exp_t        e;
        logic [9:0]  t;
        logic [5:0]  op;
        logic [4:0]  s, rt;
        logic        src;
        @(posedge Clk);
        #1;
        Reset = rst; Instruction_ID = instr; RegWrite_WB = we; Write_Register_WB = wa;
        Write_Data_WB = wd; MemRead_EX = mr; Rt_EX = rtex; PC_Plus_4_ID = $urandom;
        op = instr[31:26]; s = instr[25:21]; rt = instr[20:16];
        src = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
        t = ctl_table(op);
        e.stall = !rst && mr && rtex != 0 && (rtex == s || (rtex == rt && src));
        e.ctl   = (rst || e.stall) ? 9'd0 : t[8:0];
        e.ill   = (rst || e.stall) ? 1'b0 : t[9];
        e.r1    = mdl_read(rst, s, we, wa, wd);
        e.r2    = mdl_read(rst, rt, we, wa, wd);
        e.se    = {{16{instr[15]}}, instr[15:0]};
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        end else if (we && wa != 0) begin
            mdl_regs[wa] = wd;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ctl", {23'd0, RegDst_ID, ALUSrc_ID, MemtoReg_ID, RegWrite_ID, MemRead_ID,
                            MemWrite_ID, Branch_ID, ALUOp_ID}, {23'd0, e.ctl});
                chk("illegal", {31'd0, Illegal_Opcode_ID}, {31'd0, e.ill});
                chk("stall", {31'd0, Stall}, {31'd0, e.stall});
                chk("rd1", Read_Data_1_ID, e.r1);
                chk("rd2", Read_Data_2_ID, e.r2);
                chk("sext", Sign_Extend_Instruction_ID, e.se);
            end
        end
    end

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin : stim
        logic [5:0] op;
        logic [5:0] ops [6];
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd8; ops[5] = 6'd0;
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        Reset = 1'b1; Instruction_ID = 0; PC_Plus_4_ID = 0; RegWrite_WB = 0;
        Write_Register_WB = 0; Write_Data_WB = 0; MemRead_EX = 0; Rt_EX = 0;

        drive(1, r_type(1, 2, 3), 1, 4, 32'hAAAA5555, 1, 1);
        drive(1, 32'h0000_8000, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++) drive(0, r_type(5'(i), 5'(i), 5'd1), 0, 0, 0, 0, 0);
        drive(0, r_type(0, 0, 0), 1, 5, 32'hDEADBEEF, 0, 0);
        drive(0, r_type(5, 0, 6), 0, 0, 0, 0, 0);
        drive(0, i_type(6'd43, 9, 8, 16'd4), 1, 8, 32'h12345678, 0, 0);
        drive(0, r_type(0, 8, 1), 1, 0, 32'hFFFFFFFF, 0, 0);
        drive(0, i_type(6'd4, 3, 4, 16'hFFFE), 0, 0, 0, 1, 3);
        drive(0, i_type(6'd4, 3, 4, 16'hFFFE), 0, 0, 0, 0, 3);
        drive(0, i_type(6'd8, 7, 3, 16'd1), 0, 0, 0, 1, 3);
        drive(0, i_type(6'd35, 0, 2, 16'd8), 0, 0, 0, 1, 0);
        drive(0, {6'h3F, 26'h1234567}, 0, 0, 0, 0, 0);
        drive(0, r_type(9, 3, 1), 1, 3, 32'h0BADF00D, 1, 3);
        drive(0, r_type(9, 3, 1), 0, 0, 0, 0, 0);
        drive(1, r_type(5, 8, 1), 1, 5, 32'h11111111, 0, 0);
        drive(0, r_type(5, 8, 1), 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            drive(($urandom_range(0, 49) == 0), i_type(op, rreg(), rreg(), 16'($urandom)),
                  1'($urandom), rreg(), $urandom, 1'($urandom), rreg());
        end

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge Clk);
        @(posedge Clk);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
